// File: rtl/key_scanner_pkg.sv
// key_scanner_pkg: shared FSM state encoding and auto-repeat timing
// defaults for the keypad scanner.
package key_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Auto-repeat timing, counted in row samples while a key is held.
    localparam int REPEAT_DLY = 32;
    localparam int REPEAT_PER = 8;

endpackage

// File: rtl/key_scanner_timer.sv
// scan_timer: counts SETTLE_CYC clock cycles per column and raises
// 'sample' during the last cycle of each settle period.
module scan_timer #(
    parameter int SETTLE_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic sample
);

    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [TW-1:0] cnt;

    assign sample = (cnt == TW'(SETTLE_CYC - 1));

    // Settle counter: restarts at the end of each period, never exceeds SETTLE_CYC-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (sample) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_scanner.sv
// key_scanner: column-scanned keypad reader with debounced press/release.
// Optional feature: define KEY_SCANNER_AUTOREPEAT_EN to re-strobe key_valid
// while a key stays held (first after REPEAT_DLY samples, then every
// REPEAT_PER samples). dbg_state exposes the FSM state for observation.
module key_scanner
    import key_scanner_pkg::*;
#(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int SETTLE_CYC   = 1000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic [COLS-1:0]                        col_n,
    input  logic [ROWS-1:0]                        row_n,
    output logic [$clog2(COLS)+$clog2(ROWS)-1:0]   key_code,
    output logic                                   key_valid,
    output logic                                   key_pressed,
    output state_t                                 dbg_state
);

    localparam int CB = $clog2(COLS);
    localparam int RB = $clog2(ROWS);
    localparam int CW = CB + RB;
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);

    state_t          state;
    logic [CB-1:0]   col_idx;
    logic [RB-1:0]   cand_row;
    logic [MW-1:0]   match_cnt;
    logic [ROWS-1:0] row_s1;
    logic [ROWS-1:0] row_s;
    logic            sample;
    logic [RB-1:0]   low_row;
    logic            any_low;
    logic            cand_low;

`ifdef KEY_SCANNER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    logic [RW-1:0]   rep_cnt;
    logic            rep_first;
`endif

    // Lowest-index row that reads low; that row wins when several are pressed.
    function automatic logic [RB-1:0] lowest_low(input logic [ROWS-1:0] r);
        lowest_low = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r[i]) lowest_low = RB'(i);
        end
    endfunction

    function automatic logic [CW-1:0] code_of(input logic [CB-1:0] c, input logic [RB-1:0] r);
        code_of = CW'(c) * CW'(ROWS) + CW'(r);
    endfunction

    assign low_row   = lowest_low(row_s);
    assign any_low   = ~&row_s;
    assign cand_low  = ~row_s[cand_row];
    assign dbg_state = state;

    scan_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .sample (sample)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= '1;
            row_s  <= '1;
        end else begin
            row_s1 <= row_n;
            row_s  <= row_s1;
        end
    end

    // Scan/debounce FSM; col_n, key_code, key_valid and key_pressed are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            col_n       <= {{(COLS-1){1'b1}}, 1'b0};
            col_idx     <= '0;
            cand_row    <= '0;
            match_cnt   <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
`ifdef KEY_SCANNER_AUTOREPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            cand_row <= low_row;
                            if (DEBOUNCE_CNT == 1) begin
                                state       <= HELD;
                                match_cnt   <= '0;
                                key_code    <= code_of(col_idx, low_row);
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
`ifdef KEY_SCANNER_AUTOREPEAT_EN
                                rep_cnt     <= '0;
                                rep_first   <= 1'b1;
`endif
                            end else begin
                                state     <= CONFIRM;
                                match_cnt <= MW'(1);
                            end
                        end else begin
                            col_n   <= {col_n[COLS-2:0], col_n[COLS-1]};
                            col_idx <= (col_idx == CB'(COLS - 1)) ? '0 : col_idx + 1'b1;
                        end
                    end
                    CONFIRM: begin
                        if (cand_low) begin
                            if (match_cnt >= MW'(DEBOUNCE_CNT - 1)) begin
                                state       <= HELD;
                                match_cnt   <= '0;
                                key_code    <= code_of(col_idx, cand_row);
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
`ifdef KEY_SCANNER_AUTOREPEAT_EN
                                rep_cnt     <= '0;
                                rep_first   <= 1'b1;
`endif
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            // Bounce: drop the candidate silently and move on.
                            state     <= SCAN;
                            match_cnt <= '0;
                            col_n     <= {col_n[COLS-2:0], col_n[COLS-1]};
                            col_idx   <= (col_idx == CB'(COLS - 1)) ? '0 : col_idx + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!cand_low) begin
                            if (DEBOUNCE_CNT == 1) begin
                                state       <= SCAN;
                                key_pressed <= 1'b0;
                                col_n       <= {col_n[COLS-2:0], col_n[COLS-1]};
                                col_idx     <= (col_idx == CB'(COLS - 1)) ? '0 : col_idx + 1'b1;
                            end else begin
                                state     <= RELEASE;
                                match_cnt <= MW'(1);
                            end
                        end else begin
`ifdef KEY_SCANNER_AUTOREPEAT_EN
                            if (rep_cnt + 1'b1 == (rep_first ? RW'(REPEAT_DLY) : RW'(REPEAT_PER))) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (!cand_low) begin
                            if (match_cnt >= MW'(DEBOUNCE_CNT - 1)) begin
                                state       <= SCAN;
                                match_cnt   <= '0;
                                key_pressed <= 1'b0;
                                col_n       <= {col_n[COLS-2:0], col_n[COLS-1]};
                                col_idx     <= (col_idx == CB'(COLS - 1)) ? '0 : col_idx + 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            state     <= HELD;
                            match_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule
